mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Control unit for the multicycle ARM-subset processor. It sits directly upstream of the datapath and drives every datapath select and enable.
- Consumes the latched instruction fields and the ALU flags. Contains three parts:
  - a Moore main FSM;
  - combinational instruction and ALU decoders;
  - condition-check logic with architectural NZCV flag storage.
- Supported instructions: data processing (ADD, SUB, AND, ORR, CMP; register or immediate operand), LDR/STR with immediate offset, and B.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Instr  in  20  instruction bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  NZCV from the ALU: [3]=N, [2]=Z, [1]=C, [0]=V
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  address select: 0 = PC, 1 = Result
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
- ALUSrcA  out  2  00 = A, 01 = PC
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  equal to op
- ALUControl  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR

Behaviour:
- Reset:
  - State = FETCH; Flags = 0000; CondExR = 0.
  - Outputs take the FETCH-state values while reset is held, including IRWrite = 1 and PCWrite = 1.
  - Reset asserted mid-instruction aborts the instruction immediately; no residual writes.
- Main FSM states and transitions:
  - FETCH -> DECODE.
  - DECODE:
    - op = 01 -> MEMADR
    - op = 00 and funct[5] = 0 -> EXECUTER
    - op = 00 and funct[5] = 1 -> EXECUTEI
    - op = 10 -> BRANCH
    - op = 11 -> FETCH (treated as NOP, no writes)
  - MEMADR: funct[0] = 1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- State outputs (unlisted signals are 0 / 00):
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 01, ALUSrcB = 10, ALUOp = 0, ResultSrc = 10, NextPC = 1.
  - DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
  - MEMADR: ALUSrcA = 00, ALUSrcB = 01.
  - MEMRD: AdrSrc = 1, ResultSrc = 00.
  - MEMWB: ResultSrc = 01, RegW = 1.
  - MEMWR: AdrSrc = 1, ResultSrc = 00, MemW = 1.
  - EXECUTER: ALUSrcB = 00, ALUOp = 1.
  - EXECUTEI: ALUSrcB = 01, ALUOp = 1.
  - ALUWB: ResultSrc = 00, RegW = 1.
  - BRANCH: ALUSrcB = 01, ResultSrc = 10, Branch = 1.
- ALU decoder:
  - ALUOp = 0: ALUControl = ADD, FlagW = 00.
  - ALUOp = 1, decoded from funct[4:1]:
    - 0100 -> ADD
    - 0010 -> SUB
    - 0000 -> AND
    - 1100 -> ORR
    - 1010 (CMP) -> SUB with NoWrite = 1
    - any other code -> ADD with FlagW = 00
  - FlagW[1] = funct[0].
  - FlagW[0] = funct[0] and (ALUControl is ADD or SUB).
- Instruction decoder:
  - ImmSrc = op.
  - RegSrc[0] = (op == 10).
  - RegSrc[1] = (op == 01).
- Condition logic:
  - CondEx is a combinational function of Instr[31:28] and the stored Flags:
    - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V
    - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V
    - GT ~Z&(N==V); LE Z|(N!=V)
    - AL (1110) -> 1; 1111 -> 0
  - CondExR is a flop that captures CondEx every cycle; it is valid from DECODE onward.
  - Flags[3:2] load ALUFlags[3:2] when FlagW[1] & CondEx.
  - Flags[1:0] load ALUFlags[1:0] when FlagW[0] & CondEx.
  - Flags update at the end of the EXECUTE cycle; a following instruction sees the new flags.
- Output gating:
  - PCS = Branch | (RegW & Rd == 1111).
  - PCWrite = NextPC | (PCS & CondExR).
  - RegWrite = RegW & CondExR & ~NoWrite.
  - MemWrite = MemW & CondExR.
- Latency per instruction:
  - LDR: 5 cycles
  - STR: 4 cycles
  - data processing: 4 cycles
  - B: 3 cycles
  - op = 11: 2 cycles
- A failed condition still walks the full state sequence with all writes suppressed.

Test Plan:
- Reset: assert reset mid-MEMRD -> state FETCH immediately (asynchronous); Flags = 0000; after release, IRWrite = 1 and PCWrite = 1 in the first cycle.
- ADD R1,R2,R3 (0xE0821003): states FETCH, DECODE, EXECUTER, ALUWB; ALUControl = 00 in EXECUTER; RegWrite = 1 only in ALUWB; flags unchanged.
- LDR R2,[R0,#4] (0xE5902004), 5 cycles: ALUSrcB = 01 in MEMADR; AdrSrc = 1 in MEMRD; ResultSrc = 01 and RegWrite = 1 in MEMWB. STR R2,[R0,#8] (0xE5802008): MemWrite = 1 only in MEMWR.
- CMP R1,R1 (0xE1510001) with ALUFlags = 0100 -> ALUControl = 01; Flags = 0100; RegWrite = 0 in ALUWB. Then BEQ (0x0A000002) -> PCWrite = 1 in BRANCH.
- Flags Z = 0 then BEQ -> PCWrite = 0 in BRANCH. ADDNE (0x10821003) with Z = 1 -> RegWrite = 0 throughout.
- ADD PC,R2,R3 (Rd = 15, 0xE082F003) -> PCWrite = 1 and RegWrite = 1 in ALUWB. Op = 11 word -> FETCH, DECODE, FETCH with no writes.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle ARM-subset processor.
// It drives every datapath select and enable from the latched instruction
// fields and the ALU flags. It is made of a Moore main FSM, combinational
// instruction/ALU decoders, and condition logic with NZCV flag storage.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   Instr      in   instruction bits [31:12]: cond, op, funct, Rd
//   ALUFlags   in   NZCV from the ALU ([3]=N [2]=Z [1]=C [0]=V)
//   PCWrite    out  PC register enable
//   MemWrite   out  memory write strobe
//   RegWrite   out  register file write enable
//   IRWrite    out  instruction register enable
//   AdrSrc     out  address select (0 = PC, 1 = Result)
//   RegSrc     out  [0]: RA1 = R15, [1]: RA2 = Rd
//   ALUSrcA    out  00 = A, 01 = PC
//   ALUSrcB    out  00 = WriteData, 01 = ExtImm, 10 = constant 4
//   ResultSrc  out  00 = ALUOut, 01 = Data, 10 = ALUResult
//   ImmSrc     out  immediate extension select (equal to op)
//   ALUControl out  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t state, state_next;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  // Internal FSM controls
  logic       next_pc;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       alu_op;

  // Decoder / condition signals
  logic [1:0] flag_w;
  logic       no_write;
  logic       legal_op;
  logic       cond_ex;
  logic       cond_ex_r;
  logic [3:0] flags;
  logic       pcs;

  // Main FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Main FSM: next state and Moore outputs
  always_comb begin
    state_next = state;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_pc    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        alu_op     = 1'b1;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // ALU decoder; unrecognised function codes fall back to ADD with no flag writes
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    legal_op   = 1'b1;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: begin
          ALUControl = 2'b00;
          legal_op   = 1'b0;
        end
      endcase
      flag_w[1] = funct[0] & legal_op;
      flag_w[0] = funct[0] & legal_op & ~ALUControl[1];
    end
  end

  // CMP suppresses the register write in ALUWB, where ALUOp is already 0,
  // so this is decoded from the instruction fields rather than from ALUOp.
  assign no_write = (op == 2'b00) && (funct[4:1] == 4'b1010);

  // Instruction decoder
  assign ImmSrc    = op;
  assign RegSrc[0] = (op == 2'b10);
  assign RegSrc[1] = (op == 2'b01);

  // Condition check against the stored NZCV flags
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= '0;
      cond_ex_r <= 1'b0;
    end else begin
      cond_ex_r <= cond_ex;
      if (flag_w[1] && cond_ex) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && cond_ex) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Output gating by the registered condition result
  assign pcs      = branch | (reg_w & (rd == 4'b1111));
  assign PCWrite  = next_pc | (pcs & cond_ex_r);
  assign RegWrite = reg_w & cond_ex_r & ~no_write;
  assign MemWrite = mem_w & cond_ex_r;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed instruction sequences followed by
// random instructions. An instruction-level reference model pushes the
// expected output word for every cycle into a scoreboard queue; a monitor
// pops and compares one entry at each falling clock edge.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  typedef struct {
    logic [16:0] v;
    int unsigned instr;
    int unsigned step;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned instr_no = 0;
  int unsigned step_no = 0;
  logic [3:0]  mflags;   // model NZCV
  logic [16:0] actual;

  assign actual = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  // Expected output word; RegSrc and ImmSrc follow directly from op
  function automatic logic [16:0] pack(input logic pcw, input logic memw,
                                       input logic regw, input logic irw,
                                       input logic adr, input logic [1:0] asa,
                                       input logic [1:0] asb, input logic [1:0] rs,
                                       input logic [1:0] alc, input logic [1:0] op);
    logic [1:0] regsrc;
    regsrc = {op == 2'b01, op == 2'b10};
    return {pcw, memw, regw, irw, adr, regsrc, asa, asb, rs, op, alc};
  endfunction

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  task automatic cyc(input logic [31:0] w, input logic rst, input logic [3:0] af,
                     input logic [16:0] e);
    @(posedge clk);
    #1;
    reset    = rst;
    Instr    = w[31:12];
    ALUFlags = af;
    step_no++;
    sb.push_back('{e, instr_no, step_no});
  endtask

  // Runs one instruction through the model; af_exec is what the ALU reports
  // during the execute cycle of a data-processing instruction.
  task automatic run_instr(input logic [31:0] w, input logic [3:0] af_exec);
    logic [3:0] cnd, rd, code;
    logic [1:0] op, alc;
    logic [5:0] funct;
    logic       ok, rd15, arith, legal;
    cnd   = w[31:28];
    op    = w[27:26];
    funct = w[25:20];
    rd    = w[15:12];
    code  = funct[4:1];
    ok    = cond_holds(cnd, mflags);
    rd15  = (rd == 4'hF);
    instr_no++;
    step_no = 0;
    cyc(w, 1'b0, rnd4(), pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, op));
    cyc(w, 1'b0, rnd4(), pack(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, op));
    case (op)
      2'b01: begin
        cyc(w, 1'b0, rnd4(), pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, op));
        if (funct[0]) begin
          cyc(w, 1'b0, rnd4(), pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op));
          cyc(w, 1'b0, rnd4(), pack(ok && rd15, 0, ok, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, op));
        end else begin
          cyc(w, 1'b0, rnd4(), pack(0, ok, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op));
        end
      end
      2'b00: begin
        legal = 1'b1;
        arith = 1'b0;
        case (code)
          4'b0100: begin alc = 2'b00; arith = 1'b1; end
          4'b0010: begin alc = 2'b01; arith = 1'b1; end
          4'b1010: begin alc = 2'b01; arith = 1'b1; end
          4'b0000: alc = 2'b10;
          4'b1100: alc = 2'b11;
          default: begin alc = 2'b00; legal = 1'b0; end
        endcase
        cyc(w, 1'b0, af_exec,
            pack(0, 0, 0, 0, 0, 2'b00, funct[5] ? 2'b01 : 2'b00, 2'b00, alc, op));
        if (ok && funct[0] && legal) begin
          mflags[3:2] = af_exec[3:2];
          if (arith) mflags[1:0] = af_exec[1:0];
        end
        cyc(w, 1'b0, rnd4(),
            pack(ok && rd15, 0, ok && (code != 4'b1010), 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, op));
      end
      2'b10: begin
        cyc(w, 1'b0, rnd4(), pack(ok, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, op));
      end
      default: ;
    endcase
  endtask

  // LDR that is interrupted by reset part-way through its MEMRD cycle
  task automatic ldr_with_reset(input logic [31:0] w);
    logic [16:0] fetch_exp;
    instr_no++;
    step_no = 0;
    fetch_exp = pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, w[27:26]);
    cyc(w, 1'b0, rnd4(), fetch_exp);
    cyc(w, 1'b0, rnd4(), pack(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, w[27:26]));
    cyc(w, 1'b0, rnd4(), pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, w[27:26]));
    @(posedge clk);
    #3;
    reset = 1'b1;
    mflags = 4'b0000;
    step_no++;
    sb.push_back('{fetch_exp, instr_no, step_no});
    cyc(w, 1'b1, rnd4(), fetch_exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cnd, code, rd;
    logic [1:0] op;
    logic [5:0] funct;
    cnd   = rnd4();
    op    = 2'($urandom);
    rd    = rnd4();
    funct = 6'($urandom);
    if (op == 2'b00) begin
      case ($urandom_range(4))
        0: code = 4'b0100;
        1: code = 4'b0010;
        2: code = 4'b0000;
        3: code = 4'b1100;
        default: code = 4'b1010;
      endcase
      funct[4:1] = code;
      if (code == 4'b1010) begin
        funct[0] = 1'b1;
        rd       = 4'h0;
      end
    end
    return {cnd, op, funct, rnd4(), rd, 12'($urandom)};
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (actual === e.v) passes++;
        else $display("FAIL outputs instr %0d cycle %0d: got %05h want %05h",
                      e.instr, e.step, actual, e.v);
      end
    end
  end

  // Stimulus
  initial begin
    logic [16:0] rst_exp;
    reset    = 1'b1;
    Instr    = '0;
    ALUFlags = '0;
    mflags   = 4'b0000;
    rst_exp  = pack(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
    for (int unsigned i = 0; i < 3; i++) cyc(32'h0, 1'b1, 4'h0, rst_exp);

    run_instr(32'hE0821003, 4'b1111);   // ADD R1,R2,R3 (S=0, flags unchanged)
    run_instr(32'h0A000002, rnd4());    // BEQ with Z=0: not taken
    run_instr(32'hE5902004, rnd4());    // LDR
    run_instr(32'hE5802008, rnd4());    // STR
    run_instr(32'hE1510001, 4'b0100);   // CMP R1,R1 -> Z=1
    run_instr(32'h0A000002, rnd4());    // BEQ taken
    run_instr(32'h10821003, rnd4());    // ADDNE with Z=1: no write
    run_instr(32'hE1510001, 4'b0000);   // CMP -> Z=0
    run_instr(32'h0A000002, rnd4());    // BEQ not taken
    run_instr(32'h10821003, rnd4());    // ADDNE executes
    run_instr(32'hE082F003, rnd4());    // ADD PC,R2,R3
    run_instr(32'hEC000000, rnd4());    // op=11 NOP
    run_instr(32'hE1510001, 4'b1010);   // CMP -> N=1, C=1
    run_instr(32'h4A000000, rnd4());    // BMI taken
    ldr_with_reset(32'hE5902004);
    run_instr(32'h4A000000, rnd4());    // BMI after reset: flags cleared
    run_instr(32'h2A000000, rnd4());    // BCS after reset: not taken

    for (int unsigned i = 0; i < 300; i++) run_instr(rand_instr(), rnd4());

    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
